lsu_bus_ctrl: RTL and testbench
===============================

# lsu_bus_ctrl

Load/store bus controller between the multicycle control unit/datapath and the data RAM bus. It takes one memory request per store or load instruction: address from the ALU result, store data from rs2, width/sign code from funct3. It runs a request/ready handshake on the RAM bus with byte-lane enables. It returns aligned, sign- or zero-extended load data with a one-cycle completion pulse, so the control unit's memory state can wait on `done` instead of a fixed cycle count.

## Interface
- `TIMEOUT_CYCLES`, 16: bus-wait cycles before abort with error; range 1..255.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high; sampled on `clk`.
- `req` in 1: start a transaction; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `funct3` in 3: instrCode[14:12]; 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `rdata` out 32: extended load result; registered, held until next completed load.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; misaligned, illegal funct3 or timeout.
- `busy` out 1: high in every state except IDLE.
- `bus_req` out 1: bus request valid.
- `bus_we` out 1: bus write enable.
- `bus_addr` out 32: word address {addr[31:2], 2'b00}.
- `bus_be` out 4: byte-lane enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ready` in 1: RAM accepts/completes the access in the same cycle.
- `bus_rdata` in 32: RAM word, valid while `bus_ready`=1 on a read.

## Operation
- States: IDLE, BUS, DONE.
- IDLE: if `req`=1, latch `we`, `funct3`, `addr`, `wdata` and check legality.
  - Illegal funct3 (011, 110, 111, or 1xx with `we`=1), H with addr[0]=1, or W with addr[1:0]≠0 is an error. Go to DONE with error flag set. No bus cycle is issued.
  - Otherwise go to BUS.
- BUS: `bus_req`=1. `bus_we`, `bus_addr`, `bus_be`, `bus_wdata` come from the latched copies and stay stable.
  - On an edge with `bus_ready`=1: capture the extended `bus_rdata` into `rdata` (loads only) and go to DONE with error flag clear.
  - Otherwise increment the wait counter. When the counter reaches `TIMEOUT_CYCLES`, go to DONE with error flag set; `rdata` is unchanged.
- DONE: `done`=1 and `err`=error flag for this one cycle, then go to IDLE.
- Byte enables:
  - B: 4'b0001 << addr[1:0]
  - H: 4'b0011 << {addr[1],1'b0}
  - W: 4'b1111
  - Loads drive the same `bus_be`.
- Store data: B is {4{wdata[7:0]}}, H is {2{wdata[15:0]}}, W is wdata.
- Load extract: select the byte or half by addr[1:0]. B/H sign-extend from bit 7/15. BU/HU zero-extend. W passes through.
- `req` while `busy` is ignored; no queuing.
- Reset: state IDLE, wait counter 0, and all outputs 0 (`rdata`, `done`, `err`, `busy`, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`).
- Reset mid-transaction abandons the access; `bus_req` is low from the cycle after the reset edge.

## Timing
- `req` is sampled at edge N.
- Legal access: `bus_req` is high from cycle N+1.
  - Zero-wait RAM (`bus_ready`=1 in cycle N+1) gives `done` in cycle N+2. This is minimum latency 2.
  - Each ready-low cycle adds 1.
- Error access: `done`=`err`=1 in cycle N+1, `bus_req` never asserted.
- Timeout: `bus_req` is high for exactly `TIMEOUT_CYCLES` cycles. `done`/`err` follow in the next cycle.
- `bus_req` drops the cycle after the `bus_ready` edge. It is never high in DONE or IDLE.
- Next `req` is accepted at the earliest in the cycle after `done`, when back in IDLE.
- `bus_ready` outside BUS is ignored.

## Structure
- Shared defines package holds:
  - funct3 width codes `LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`
  - the lsu state enum
- Combinational sub-module `lsu_align` contains:
  - `be`/`wdata` generation from (funct3, addr[1:0], wdata)
  - load extract/extend from (funct3, addr[1:0], bus_rdata)
  - misalignment/illegal detect
- The top holds the FSM, latches, wait counter and `rdata` register.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, zero-wait RAM: `bus_be`=1111, `bus_addr`=0x100, `bus_wdata`=0xDEADBEEF, `done` 2 cycles after `req`, `err`=0.
- SB addr 0x103, wdata 0x000000A5: `bus_be`=1000, `bus_wdata`=0xA5A5A5A5, `bus_addr`=0x100.
- RAM word 0x80F07F01 at 0x200, 3 ready-low cycles:
  - LB @0x201 gives `rdata`=0x0000007F; LB @0x203 gives 0xFFFFFF80.
  - LBU @0x203 gives 0x00000080; LH @0x202 gives 0xFFFF80F0.
  - Each `done` arrives 5 cycles after `req`.
- LW addr 0x102 and LH addr 0x201: `done`=`err`=1 one cycle after `req`, `bus_req` never high, `rdata` unchanged.
- `bus_ready` held 0 with `TIMEOUT_CYCLES`=4: `bus_req` high exactly 4 cycles, then `done`=`err`=1.
- `reset` in the 2nd BUS cycle: `bus_req`, `busy`, `rdata` all 0 the next cycle. A `req` held high during `busy` produces no extra transaction.

Source files
------------

// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared definitions for the load/store bus controller: funct3 width codes and FSM states.
package lsu_bus_ctrl_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StDone
  } lsu_state_e;

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Data RAM bus: request/ready handshake with byte-lane enables.
interface lsu_bus_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ready, rdata);
  modport slave  (input req, we, addr, be, wdata, output ready, rdata);
endinterface

// File: rtl/lsu_bus_ctrl_align.sv
// Byte-lane/store-data generation, load extract/extend and legality check for one access.
module lsu_align
  import lsu_bus_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  output logic [31:0] load_data,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [15:0] half;

  assign shifted = bus_rdata >> {addr_lo, 3'b000};
  assign half    = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    be        = 4'b0000;
    bus_wdata = wdata;
    load_data = bus_rdata;
    illegal   = 1'b0;
    case (funct3)
      LSU_B, LSU_BU: begin
        be        = 4'b0001 << addr_lo;
        bus_wdata = {4{wdata[7:0]}};
        load_data = (funct3 == LSU_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'h0, shifted[7:0]};
        illegal   = (funct3 == LSU_BU) && we;
      end
      LSU_H, LSU_HU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        bus_wdata = {2{wdata[15:0]}};
        load_data = (funct3 == LSU_H) ? {{16{half[15]}}, half} : {16'h0, half};
        illegal   = addr_lo[0] || ((funct3 == LSU_HU) && we);
      end
      LSU_W: begin
        be      = 4'b1111;
        illegal = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one RAM access per request, done/err pulse, bounded bus wait.
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  lsu_bus_if.master   bus
);

  localparam logic [7:0] LastWait = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic        we_q, err_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic [7:0]  cnt_q;

  logic        in_idle, in_bus;
  logic [2:0]  sel_funct3;
  logic        sel_we;
  logic [1:0]  sel_addr_lo;
  logic [31:0] sel_wdata;
  logic [3:0]  be;
  logic [31:0] bus_wdata, load_data;
  logic        illegal;

  assign in_idle = (state_q == StIdle);
  assign in_bus  = (state_q == StBus);

  // Legality is judged on the live request in IDLE; afterwards the latched copy drives the lanes.
  assign sel_funct3  = in_idle ? funct3 : funct3_q;
  assign sel_we      = in_idle ? we : we_q;
  assign sel_addr_lo = in_idle ? addr[1:0] : addr_q[1:0];
  assign sel_wdata   = in_idle ? wdata : wdata_q;

  lsu_align u_align (
    .funct3    (sel_funct3),
    .we        (sel_we),
    .addr_lo   (sel_addr_lo),
    .wdata     (sel_wdata),
    .bus_rdata (bus.rdata),
    .be        (be),
    .bus_wdata (bus_wdata),
    .load_data (load_data),
    .illegal   (illegal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (req) state_d = illegal ? StDone : StBus;
      StBus:  if (bus.ready || (cnt_q == LastWait)) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      cnt_q    <= 8'h0;
      rdata    <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          cnt_q <= 8'h0;
          if (req) begin
            we_q     <= we;
            funct3_q <= funct3;
            addr_q   <= addr;
            wdata_q  <= wdata;
            err_q    <= illegal;
          end
        end
        StBus: begin
          if (bus.ready) begin
            if (!we_q) rdata <= load_data;
          end else if (cnt_q == LastWait) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = (state_q == StDone);
  assign err       = done && err_q;
  assign busy      = !in_idle;
  assign bus.req   = in_bus;
  assign bus.we    = in_bus && we_q;
  assign bus.addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.be    = in_bus ? be : 4'b0000;
  assign bus.wdata = in_bus ? bus_wdata : 32'h0;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl with a small ready-delaying RAM responder.
module tb_lsu_bus_ctrl;
  import lsu_bus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        done, err, busy;

  lsu_bus_if bus_if ();

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .funct3 (funct3),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .done   (done),
    .err    (err),
    .busy   (busy),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;

  int          lat, req_cycles;
  logic        got_done, obs_err, obs_we;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata;

  // Issue one request, respond with 'waits' ready-low cycles, return when done is seen.
  task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int waits);
    int wc = 0;
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd; bus_if.ready = 1'b0;
    @(negedge clk);
    req = 1'b0;
    lat = 1; req_cycles = 0; got_done = 1'b0; obs_err = 1'b0;
    obs_we = 1'b0; obs_be = 4'h0; obs_addr = 32'h0; obs_wdata = 32'h0;
    for (int c = 0; c < 50; c++) begin
      if (done) begin
        got_done = 1'b1;
        obs_err  = err;
        break;
      end
      if (bus_if.req) begin
        if (req_cycles == 0) begin
          obs_we = bus_if.we; obs_be = bus_if.be;
          obs_addr = bus_if.addr; obs_wdata = bus_if.wdata;
        end
        req_cycles++;
        if (wc >= waits) bus_if.ready = 1'b1;
        else begin
          bus_if.ready = 1'b0;
          wc++;
        end
      end else begin
        bus_if.ready = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus_if.ready = 1'b0;
    checks++;
    if (!got_done) $display("FAIL txn_done_timeout: done never seen, required within 50 cycles");
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_status: busy=%b done=%b err=%b, required 0 0 0", busy, done, err);
    else passed++;
    checks++;
    if (bus_if.req !== 1'b0 || bus_if.we !== 1'b0 || bus_if.be !== 4'h0)
      $display("FAIL reset_bus_ctrl: req=%b we=%b be=%b, required 0 0 0000",
               bus_if.req, bus_if.we, bus_if.be);
    else passed++;
    checks++;
    if (bus_if.addr !== 32'h0 || bus_if.wdata !== 32'h0 || rdata !== 32'h0)
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, required all 0",
               bus_if.addr, bus_if.wdata, rdata);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_store_word();
    run_txn(1'b1, LSU_W, 32'h100, 32'hDEADBEEF, 0);
    checks++;
    if (obs_be !== 4'b1111 || obs_addr !== 32'h100 || obs_we !== 1'b1)
      $display("FAIL sw_bus: be=%b addr=%h we=%b, required 1111 00000100 1", obs_be, obs_addr,
               obs_we);
    else passed++;
    checks++;
    if (obs_wdata !== 32'hDEADBEEF)
      $display("FAIL sw_wdata: got %h, required deadbeef", obs_wdata);
    else passed++;
    checks++;
    if (lat !== 2 || obs_err !== 1'b0 || req_cycles !== 1)
      $display("FAIL sw_timing: lat=%0d err=%b req_cycles=%0d, required 2 0 1", lat, obs_err,
               req_cycles);
    else passed++;
  endtask

  task automatic test_store_narrow();
    run_txn(1'b1, LSU_B, 32'h103, 32'h000000A5, 0);
    checks++;
    if (obs_be !== 4'b1000 || obs_wdata !== 32'hA5A5A5A5 || obs_addr !== 32'h100)
      $display("FAIL sb_bus: be=%b wdata=%h addr=%h, required 1000 a5a5a5a5 00000100",
               obs_be, obs_wdata, obs_addr);
    else passed++;
    run_txn(1'b1, LSU_H, 32'h102, 32'h00001234, 1);
    checks++;
    if (obs_be !== 4'b1100 || obs_wdata !== 32'h12341234 || lat !== 3 || obs_err !== 1'b0)
      $display("FAIL sh_bus: be=%b wdata=%h lat=%0d err=%b, required 1100 12341234 3 0",
               obs_be, obs_wdata, lat, obs_err);
    else passed++;
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s [4] = '{LSU_B, LSU_B, LSU_BU, LSU_H};
    logic [31:0] as  [4] = '{32'h201, 32'h203, 32'h203, 32'h202};
    logic [31:0] exp [4] = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80F0};
    logic [3:0]  ebe [4] = '{4'b0010, 4'b1000, 4'b1000, 4'b1100};
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, f3s[i], as[i], 32'hFFFFFFFF, 3);
      @(negedge clk);
      checks++;
      if (rdata !== exp[i] || obs_be !== ebe[i] || obs_we !== 1'b0)
        $display("FAIL load_%0d: rdata=%h be=%b we=%b, required %h %b 0", i, rdata, obs_be,
                 obs_we, exp[i], ebe[i]);
      else passed++;
      checks++;
      if (lat !== 5 || obs_err !== 1'b0 || obs_addr !== 32'h200)
        $display("FAIL load_%0d_timing: lat=%0d err=%b addr=%h, required 5 0 00000200", i, lat,
                 obs_err, obs_addr);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    logic        ws  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [4] = '{LSU_W, LSU_H, LSU_BU, 3'b011};
    logic [31:0] as  [4] = '{32'h102, 32'h201, 32'h200, 32'h200};
    for (int i = 0; i < 4; i++) begin
      run_txn(ws[i], f3s[i], as[i], 32'h0, 0);
      @(negedge clk);
      checks++;
      if (lat !== 1 || obs_err !== 1'b1 || req_cycles !== 0 || rdata !== 32'hFFFF80F0)
        $display("FAIL illegal_%0d: lat=%0d err=%b req_cycles=%0d rdata=%h, required 1 1 0 ffff80f0",
                 i, lat, obs_err, req_cycles, rdata);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, LSU_W, 32'h200, 32'h0, 1000);
    @(negedge clk);
    checks++;
    if (req_cycles !== 4 || lat !== 5 || obs_err !== 1'b1)
      $display("FAIL timeout: req_cycles=%0d lat=%0d err=%b, required 4 5 1", req_cycles, lat,
               obs_err);
    else passed++;
    checks++;
    if (rdata !== 32'hFFFF80F0 || busy !== 1'b0)
      $display("FAIL timeout_rdata: rdata=%h busy=%b, required ffff80f0 0", rdata, busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = LSU_W; addr = 32'h200; bus_if.ready = 1'b0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.req !== 1'b1)
      $display("FAIL reset_mid_pre: bus_req=%b, required 1", bus_if.req);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.req !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0)
      $display("FAIL reset_mid: bus_req=%b busy=%b rdata=%h, required 0 0 00000000",
               bus_if.req, busy, rdata);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_req_held();
    int rc = 0, dc = 0, wc = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = LSU_W; addr = 32'h200;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        dc++;
        req = 1'b0;
      end
      if (bus_if.req) begin
        rc++;
        if (wc >= 2) bus_if.ready = 1'b1;
        else begin
          bus_if.ready = 1'b0;
          wc++;
        end
      end else begin
        bus_if.ready = 1'b0;
      end
    end
    req = 1'b0;
    checks++;
    if (rc !== 3 || dc !== 1)
      $display("FAIL req_held: bus_req_cycles=%0d dones=%0d, required 3 1", rc, dc);
    else passed++;
    checks++;
    if (rdata !== 32'h80F07F01)
      $display("FAIL req_held_rdata: got %h, required 80f07f01", rdata);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    bus_if.ready = 1'b0;
    bus_if.rdata = 32'h80F07F01;
    test_reset();
    test_store_word();
    test_store_narrow();
    test_load_extend();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_req_held();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
